sram_1w1r_be: RTL and testbench

- Parametrised simple dual-port, single-clock RAM: one write port, one read port.
- Adds byte-lane write enables, selectable read-during-write (RDW) policy, optional output register stage, read-valid tracking, and a hardware clear sequencer that zeroes the array after reset.
- Used as the storage primitive for register files, tag/data arrays and queue bodies that need deterministic contents after reset without initialisation files.

---
 rtl/sram_1w1r_be.sv | 193 +++++++++++++++++++
 tb/tb_sram_1w1r_be.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_1w1r_be.sv
// sram_1w1r_be
// Single-clock simple dual-port RAM (one write port, one read port) with
// byte-lane write enables, selectable read-during-write behaviour, optional
// output register, read-valid tracking and a post-reset clear sequencer.
//
// Ports:
//   i_clk      clock, rising edge
//   i_rst      asynchronous active-high reset
//   i_w_e      write enable
//   i_w_be     per-lane write enable (lane k = bits [k*BYTE_W +: BYTE_W])
//   i_w_addr   write address (addresses >= DEPTH are dropped)
//   i_w_data   write data
//   i_r_e      read enable
//   i_r_addr   read address (addresses >= DEPTH read as zero)
//   o_r_data   read data (latency 1, or 2 with OUT_REG=1)
//   o_r_valid  o_r_data holds the result of an accepted read this cycle
//   o_busy     clear sequencer running; both ports are ignored
module sram_1w1r_be #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 8,
  parameter int BYTE_W       = 8,
  parameter int RDW_MODE     = 0,
  parameter int OUT_REG      = 0,
  parameter int CLEAR_ON_RST = 1,
  localparam int NB = WIDTH / BYTE_W,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_w_e,
  input  logic [NB-1:0]     i_w_be,
  input  logic [AW-1:0]     i_w_addr,
  input  logic [WIDTH-1:0]  i_w_data,
  input  logic              i_r_e,
  input  logic [AW-1:0]     i_r_addr,
  output logic [WIDTH-1:0]  o_r_data,
  output logic              o_r_valid,
  output logic              o_busy
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // One extra bit so DEPTH itself is representable for range compares.
  localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam state_t        RST_STATE = (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;

  state_t           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             clr_we;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             idle;
  logic             w_in_range, r_in_range;
  logic             wr_ok, rd_ok, rdw_hit;
  logic [WIDTH-1:0] rd_word, rd_merged;

  logic [WIDTH-1:0] rd1_q, rd1_d;
  logic             v1_q, v1_d;

  // ---------------------------------------------------------------------
  // Clear sequencer
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          // Last entry is zeroed on this edge, so ports open next cycle.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  assign o_busy = (state_q == ST_CLEAR);
  assign idle   = (state_q == ST_IDLE);

  // ---------------------------------------------------------------------
  // Port qualification
  // ---------------------------------------------------------------------
  assign w_in_range = ({1'b0, i_w_addr} < DEPTH_W);
  assign r_in_range = ({1'b0, i_r_addr} < DEPTH_W);
  assign wr_ok      = idle && i_w_e && w_in_range;
  assign rd_ok      = idle && i_r_e;
  // Forwarding only applies when both addresses hit the same real entry.
  assign rdw_hit    = (RDW_MODE != 0) && wr_ok && rd_ok && (i_w_addr == i_r_addr);

  // ---------------------------------------------------------------------
  // Storage array (no reset: contents only change on clock edges)
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (clr_we) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_ok) begin
      for (int k = 0; k < NB; k++) begin
        if (i_w_be[k]) begin
          mem_q[i_w_addr][k*BYTE_W +: BYTE_W] <= i_w_data[k*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (r_in_range) begin
      rd_word = mem_q[i_r_addr];
    end
  end

  // Per-lane new-data forwarding for same-address read during write.
  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    assign rd_merged[gi*BYTE_W +: BYTE_W] = (rdw_hit && i_w_be[gi])
                                            ? i_w_data[gi*BYTE_W +: BYTE_W]
                                            : rd_word[gi*BYTE_W +: BYTE_W];
  end

  // ---------------------------------------------------------------------
  // Read stage 1
  // ---------------------------------------------------------------------
  always_comb begin
    rd1_d = rd1_q;
    v1_d  = 1'b0;
    if (rd_ok) begin
      rd1_d = rd_merged;
      v1_d  = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd1_q <= '0;
      v1_q  <= 1'b0;
    end else begin
      rd1_q <= rd1_d;
      v1_q  <= v1_d;
    end
  end

  // ---------------------------------------------------------------------
  // Optional output stage
  // ---------------------------------------------------------------------
  if (OUT_REG != 0) begin : g_out_reg
    logic [WIDTH-1:0] rd2_q, rd2_d;
    logic             v2_q;

    always_comb begin
      rd2_d = rd2_q;
      if (v1_q) begin
        rd2_d = rd1_q;
      end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        rd2_q <= '0;
        v2_q  <= 1'b0;
      end else begin
        rd2_q <= rd2_d;
        v2_q  <= v1_q;
      end
    end

    assign o_r_data  = rd2_q;
    assign o_r_valid = v2_q;
  end else begin : g_no_out_reg
    assign o_r_data  = rd1_q;
    assign o_r_valid = v1_q;
  end

endmodule

// File: tb/tb_sram_1w1r_be.sv
// Bench for sram_1w1r_be. Two instances share one stimulus stream:
//   A: DEPTH=8, RDW_MODE=0, OUT_REG=0
//   B: DEPTH=6, RDW_MODE=1, OUT_REG=1
// A reference model tracks memory contents, clear progress and read history
// per instance and every cycle checks busy/valid/data of both.
module tb_sram_1w1r_be;

  logic        clk = 1'b0;
  logic        rst;
  logic        w_e;
  logic [3:0]  w_be;
  logic [2:0]  w_addr;
  logic [31:0] w_data;
  logic        r_e;
  logic [2:0]  r_addr;

  logic [31:0] a_data, b_data;
  logic        a_valid, b_valid, a_busy, b_busy;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  sram_1w1r_be #(
    .WIDTH(32), .DEPTH(8), .BYTE_W(8), .RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RST(1)
  ) u_a (
    .i_clk(clk), .i_rst(rst), .i_w_e(w_e), .i_w_be(w_be), .i_w_addr(w_addr),
    .i_w_data(w_data), .i_r_e(r_e), .i_r_addr(r_addr),
    .o_r_data(a_data), .o_r_valid(a_valid), .o_busy(a_busy)
  );

  sram_1w1r_be #(
    .WIDTH(32), .DEPTH(6), .BYTE_W(8), .RDW_MODE(1), .OUT_REG(1), .CLEAR_ON_RST(1)
  ) u_b (
    .i_clk(clk), .i_rst(rst), .i_w_e(w_e), .i_w_be(w_be), .i_w_addr(w_addr),
    .i_w_data(w_data), .i_r_e(r_e), .i_r_addr(r_addr),
    .o_r_data(b_data), .o_r_valid(b_valid), .o_busy(b_busy)
  );

  // ---------------- reference model ----------------
  int          dep    [2] = '{8, 6};
  bit          rdw_m  [2] = '{1'b0, 1'b1};
  int          lat    [2] = '{1, 2};
  logic [31:0] mref   [2][8];
  int          clr_left [2];
  bit          acc    [2][3];
  logic [31:0] val    [2][3];
  logic [31:0] shown  [2];

  function automatic logic [31:0] merge(logic [31:0] old_w, logic [31:0] new_w, logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) r[k*8 +: 8] = new_w[k*8 +: 8];
    end
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock: update the model from the current inputs, wait for
  // the edge, then compare both instances against the model.
  task automatic step();
    for (int i = 0; i < 2; i++) begin
      bit          accepted;
      logic [31:0] value;
      accepted = 1'b0;
      value    = '0;
      if (rst) begin
        clr_left[i] = dep[i];
        for (int j = 0; j < 3; j++) begin
          acc[i][j] = 1'b0;
          val[i][j] = '0;
        end
        shown[i] = '0;
      end else begin
        if (clr_left[i] > 0) begin
          mref[i][dep[i] - clr_left[i]] = '0;
          clr_left[i]--;
        end else begin
          if (r_e) begin
            accepted = 1'b1;
            if (int'(r_addr) < dep[i]) value = mref[i][r_addr];
            if (rdw_m[i] && w_e && (w_addr == r_addr) && (int'(w_addr) < dep[i]))
              value = merge(value, w_data, w_be);
          end
          if (w_e && (int'(w_addr) < dep[i]))
            mref[i][w_addr] = merge(mref[i][w_addr], w_data, w_be);
        end
        acc[i][2] = acc[i][1];
        acc[i][1] = acc[i][0];
        acc[i][0] = accepted;
        val[i][2] = val[i][1];
        val[i][1] = val[i][0];
        val[i][0] = value;
        if (acc[i][lat[i]-1]) shown[i] = val[i][lat[i]-1];
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    $display("c%0d rst=%0b we=%0b be=%h wa=%0d wd=%h re=%0b ra=%0d | A b=%0b v=%0b d=%h | B b=%0b v=%0b d=%h",
             cyc, rst, w_e, w_be, w_addr, w_data, r_e, r_addr,
             a_busy, a_valid, a_data, b_busy, b_valid, b_data);
    chk($sformatf("A.busy c%0d", cyc),  a_busy,  (clr_left[0] > 0));
    chk($sformatf("B.busy c%0d", cyc),  b_busy,  (clr_left[1] > 0));
    chk($sformatf("A.valid c%0d", cyc), a_valid, (!rst && acc[0][0]));
    chk($sformatf("B.valid c%0d", cyc), b_valid, (!rst && acc[1][1]));
    chk($sformatf("A.data c%0d", cyc),  a_data,  shown[0]);
    chk($sformatf("B.data c%0d", cyc),  b_data,  shown[1]);
  endtask

  task automatic op(bit r, bit we, logic [3:0] be, logic [2:0] wa, logic [31:0] wd,
                    bit re, logic [2:0] ra);
    rst    = r;
    w_e    = we;
    w_be   = be;
    w_addr = wa;
    w_data = wd;
    r_e    = re;
    r_addr = ra;
    step();
  endtask

  task automatic idle_op();
    op(1'b0, 1'b0, 4'h0, 3'd0, 32'h0, 1'b0, 3'd0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 8; j++) mref[i][j] = '0;
      clr_left[i] = 0;
      shown[i]    = '0;
    end
    rst = 1'b1; w_e = 1'b0; w_be = '0; w_addr = '0; w_data = '0; r_e = 1'b0; r_addr = '0;

    // Power-up reset and initial clear.
    op(1'b1, 1'b0, 4'h0, 3'd0, 32'h0, 1'b0, 3'd0);
    op(1'b1, 1'b0, 4'h0, 3'd0, 32'h0, 1'b0, 3'd0);
    for (int k = 0; k < 8; k++) idle_op();

    // Fill with all-ones, reset, expect 8 busy cycles then zeros everywhere.
    for (int a = 0; a < 8; a++) op(1'b0, 1'b1, 4'hF, 3'(a), 32'hFFFF_FFFF, 1'b0, 3'd0);
    op(1'b1, 1'b0, 4'h0, 3'd0, 32'h0, 1'b0, 3'd0);
    for (int k = 0; k < 8; k++) begin
      idle_op();
      if (k == 6) chk("clear A busy at 7", a_busy, 1'b1);
      if (k == 7) chk("clear A busy at 8", a_busy, 1'b0);
    end
    for (int a = 0; a < 8; a++) begin
      op(1'b0, 1'b0, 4'h0, 3'd0, 32'h0, 1'b1, 3'(a));
      chk("clear A readback", a_data, 32'h0);
    end
    idle_op();
    idle_op();

    // Byte-lane merge.
    op(1'b0, 1'b1, 4'hF, 3'd3, 32'hAABB_CCDD, 1'b0, 3'd0);
    op(1'b0, 1'b1, 4'b0101, 3'd3, 32'h1122_3344, 1'b0, 3'd0);
    op(1'b0, 1'b0, 4'h0, 3'd0, 32'h0, 1'b1, 3'd3);
    chk("lane merge A data", a_data, 32'hAA22_CC44);
    chk("lane merge A valid", a_valid, 1'b1);
    idle_op();
    chk("lane merge B data", b_data, 32'hAA22_CC44);
    idle_op();

    // Read during write to the same address.
    op(1'b0, 1'b1, 4'hF, 3'd5, 32'hDEAD_BEEF, 1'b0, 3'd0);
    op(1'b0, 1'b1, 4'hF, 3'd5, 32'h1234_5678, 1'b1, 3'd5);
    chk("rdw old A", a_data, 32'hDEAD_BEEF);
    op(1'b0, 1'b0, 4'h0, 3'd0, 32'h0, 1'b1, 3'd5);
    chk("rdw after A", a_data, 32'h1234_5678);
    chk("rdw new B", b_data, 32'h1234_5678);
    idle_op();
    chk("rdw after B", b_data, 32'h1234_5678);
    idle_op();

    // Output-register pipeline with back-to-back reads.
    for (int a = 0; a < 3; a++) op(1'b0, 1'b1, 4'hF, 3'(a), 32'(10 + a), 1'b0, 3'd0);
    for (int a = 0; a < 3; a++) op(1'b0, 1'b0, 4'h0, 3'd0, 32'h0, 1'b1, 3'(a));
    idle_op();
    chk("outreg B last data", b_data, 32'd12);
    chk("outreg B last valid", b_valid, 1'b1);
    idle_op();
    chk("outreg B hold data", b_data, 32'd12);
    chk("outreg B hold valid", b_valid, 1'b0);

    // Out-of-range address on the DEPTH=6 instance.
    op(1'b0, 1'b1, 4'hF, 3'd7, 32'hCAFE_F00D, 1'b0, 3'd0);
    op(1'b0, 1'b0, 4'h0, 3'd0, 32'h0, 1'b1, 3'd7);
    idle_op();
    chk("oob B data", b_data, 32'h0);
    chk("oob B valid", b_valid, 1'b1);
    for (int a = 0; a < 8; a++) op(1'b0, 1'b0, 4'h0, 3'd0, 32'h0, 1'b1, 3'(a));
    idle_op();
    idle_op();

    // Reset in the middle of a clear restarts it; ports ignored while busy.
    op(1'b1, 1'b0, 4'h0, 3'd0, 32'h0, 1'b0, 3'd0);
    for (int k = 0; k < 4; k++) op(1'b0, 1'b1, 4'hF, 3'(k), 32'h5555_0000 + 32'(k), 1'b1, 3'(k));
    op(1'b1, 1'b0, 4'h0, 3'd0, 32'h0, 1'b0, 3'd0);
    op(1'b1, 1'b0, 4'h0, 3'd0, 32'h0, 1'b0, 3'd0);
    for (int k = 0; k < 8; k++) begin
      op(1'b0, 1'b1, 4'hF, 3'(k), 32'h7777_0000 + 32'(k), 1'b1, 3'(7 - k));
      if (k == 6) chk("restart A busy at 7", a_busy, 1'b1);
      if (k == 7) chk("restart A busy at 8", a_busy, 1'b0);
    end
    for (int a = 0; a < 8; a++) op(1'b0, 1'b0, 4'h0, 3'd0, 32'h0, 1'b1, 3'(a));
    idle_op();
    idle_op();

    // Randomised traffic with frequent same-address collisions.
    for (int n = 0; n < 200; n++) begin
      logic [2:0] wa, ra;
      wa = 3'($urandom_range(0, 7));
      ra = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) wa = ra;
      op(1'b0, 1'($urandom_range(0, 1)), 4'($urandom), wa, $urandom,
         1'($urandom_range(0, 1)), ra);
    end
    idle_op();
    idle_op();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
